// File: rtl/lfsr_block_sync.sv
// 64b66b receive block lock: hunts for sync-header alignment with bitslip requests
// and forwards aligned, still-scrambled blocks to the descrambler.
//
// state  | meaning
// INIT   | one cycle after reset, counters cleared
// SEARCH | counting consecutive valid headers toward lock
// SLIP   | bitslip pulse to the gearbox
// WAIT   | ignoring input while the gearbox realigns
// LOCKED | aligned; invalid headers tracked per window
module lfsr_block_sync #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int LOCK_CNT   = 64,
  parameter int ERR_LIMIT  = 16,
  parameter int SLIP_WAIT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [HDR_WIDTH-1:0]  hdr_in,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [HDR_WIDTH-1:0]  hdr_out,
  output logic                  out_valid,
  output logic                  bitslip,
  output logic                  block_lock,
  output logic [7:0]            err_count
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W = $clog2(ERR_LIMIT + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] LOCK_FULL = CNT_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0] ERR_FULL  = BAD_W'(ERR_LIMIT);
  localparam logic [7:0]       WAIT_LOAD = 8'(SLIP_WAIT - 1);

  typedef enum logic [2:0] {
    ST_INIT, ST_SEARCH, ST_SLIP, ST_WAIT, ST_LOCKED
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] sh_cnt, sh_nxt, win_cnt, win_nxt, win_step;
  logic [BAD_W-1:0] bad_cnt, bad_nxt, bad_step;
  logic [7:0]       wait_cnt, wait_nxt, err_nxt;
  logic             hdr_ok;

  assign hdr_ok = hdr_in[0] ^ hdr_in[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      sh_cnt    <= '0;
      win_cnt   <= '0;
      bad_cnt   <= '0;
      wait_cnt  <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      sh_cnt    <= sh_nxt;
      win_cnt   <= win_nxt;
      bad_cnt   <= bad_nxt;
      wait_cnt  <= wait_nxt;
      err_count <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh_cnt;
    win_nxt   = win_cnt;
    bad_nxt   = bad_cnt;
    wait_nxt  = wait_cnt;
    err_nxt   = err_count;
    win_step  = win_cnt + CNT_W'(1);
    bad_step  = bad_cnt + BAD_W'(hdr_ok ? 0 : 1);
    case (state)
      ST_INIT: begin
        state_nxt = ST_SEARCH;
        sh_nxt    = '0;
        win_nxt   = '0;
        bad_nxt   = '0;
        wait_nxt  = '0;
      end
      ST_SEARCH: begin
        if (in_valid) begin
          if (!hdr_ok) begin
            state_nxt = ST_SLIP;
            sh_nxt    = '0;
          end else if (sh_cnt == LOCK_LAST) begin
            state_nxt = ST_LOCKED;
            sh_nxt    = '0;
            win_nxt   = '0;
            bad_nxt   = '0;
          end else begin
            sh_nxt = sh_cnt + CNT_W'(1);
          end
        end
      end
      ST_SLIP: begin
        state_nxt = ST_WAIT;
        wait_nxt  = WAIT_LOAD;
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = ST_SEARCH;
          sh_nxt    = '0;
        end else begin
          wait_nxt = wait_cnt - 8'd1;
        end
      end
      ST_LOCKED: begin
        if (in_valid) begin
          if (!hdr_ok && err_count != 8'hFF) err_nxt = err_count + 8'd1;
          // Losing lock wins over a window rollover on the same header.
          if (bad_step == ERR_FULL) begin
            state_nxt = ST_SLIP;
            win_nxt   = '0;
            bad_nxt   = '0;
          end else if (win_step == LOCK_FULL) begin
            win_nxt = '0;
            bad_nxt = '0;
          end else begin
            win_nxt = win_step;
            bad_nxt = bad_step;
          end
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign bitslip    = (state == ST_SLIP);
  assign block_lock = (state == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      hdr_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        data_out <= data_in;
        hdr_out  <= hdr_in;
      end
      out_valid <= in_valid && (state == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_lfsr_block_sync.sv
// Directed bench for lfsr_block_sync: lock, slip timing, window tolerance,
// loss of lock, gapped input and reset in WAIT/LOCKED.
module tb_lfsr_block_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic [1:0]  hdr_in;
  logic        in_valid;
  logic [63:0] data_out;
  logic [1:0]  hdr_out;
  logic        out_valid, bitslip, block_lock;
  logic [7:0]  err_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] seq = 32'h1000;
  int          slip_total = 0;
  int          b2b = 0;
  logic        prev_slip = 1'b0;
  int          snap;
  logic [63:0] last_data;

  lfsr_block_sync dut (
    .clk(clk), .rst(rst), .data_in(data_in), .hdr_in(hdr_in), .in_valid(in_valid),
    .data_out(data_out), .hdr_out(hdr_out), .out_valid(out_valid),
    .bitslip(bitslip), .block_lock(block_lock), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bitslip === 1'b1) slip_total <= slip_total + 1;
    if (bitslip === 1'b1 && prev_slip === 1'b1) b2b <= b2b + 1;
    prev_slip <= bitslip;
  end

  task automatic send(input logic [1:0] h, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      hdr_in   = h;
      in_valid = v;
      seq      = seq + 32'd1;
      data_in  = {seq, ~seq};
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_lock"}, 64'(block_lock), 64'd0);
    chk({tag, "_slip"}, 64'(bitslip), 64'd0);
    chk({tag, "_oval"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"}, data_out, 64'd0);
    chk({tag, "_hdr"}, 64'(hdr_out), 64'd0);
    chk({tag, "_err"}, 64'(err_count), 64'd0);
  endtask

  initial begin
    rst = 1'b1; hdr_in = 2'b11; in_valid = 1'b1; data_in = 64'hDEAD_BEEF_0BAD_F00D;
    send(2'b11, 1'b1, 2);
    chk_reset_outputs("reset");
    rst = 1'b0;
    send(2'b01, 1'b0, 1);

    // Acquisition: 64 valid headers
    send(2'b01, 1'b1, 63);
    chk("acq_lock_63", 64'(block_lock), 64'd0);
    send(2'b01, 1'b1, 1);
    chk("acq_lock_64", 64'(block_lock), 64'd1);
    chk("acq_oval_lock_edge", 64'(out_valid), 64'd0);
    send(2'b10, 1'b1, 1);
    chk("acq_oval_next", 64'(out_valid), 64'd1);
    chk("acq_data", data_out, {seq, ~seq});
    chk("acq_hdr", 64'(hdr_out), 64'd2);
    send(2'b01, 1'b1, 63);

    // Four windows with 15 bad headers each
    snap = slip_total;
    send(2'b00, 1'b1, 15); send(2'b01, 1'b1, 49);
    chk("win1_lock", 64'(block_lock), 64'd1);
    chk("win1_err", 64'(err_count), 64'd15);
    send(2'b10, 1'b1, 49); send(2'b11, 1'b1, 15);
    chk("win2_lock", 64'(block_lock), 64'd1);
    chk("win2_err", 64'(err_count), 64'd30);
    for (int k = 0; k < 15; k++) begin
      send(2'b11, 1'b1, 1); send(2'b01, 1'b1, 3);
    end
    send(2'b10, 1'b1, 4);
    chk("win3_lock", 64'(block_lock), 64'd1);
    chk("win3_err", 64'(err_count), 64'd45);
    send(2'b00, 1'b1, 15); send(2'b10, 1'b1, 49);
    chk("win4_lock", 64'(block_lock), 64'd1);
    chk("win4_err", 64'(err_count), 64'd60);
    chk("win_no_slip", 64'(slip_total - snap), 64'd0);

    // Loss of lock: 16 bad interleaved with 40 good in one window
    for (int k = 0; k < 15; k++) begin
      send(2'b11, 1'b1, 1); send(2'b01, 1'b1, 2);
    end
    send(2'b01, 1'b1, 10);
    chk("loss_lock_15bad", 64'(block_lock), 64'd1);
    send(2'b11, 1'b1, 1);
    chk("loss_lock", 64'(block_lock), 64'd0);
    chk("loss_slip", 64'(bitslip), 64'd1);
    chk("loss_err", 64'(err_count), 64'd76);
    chk("loss_bad_fwd_oval", 64'(out_valid), 64'd1);
    chk("loss_bad_fwd_hdr", 64'(hdr_out), 64'd3);

    // WAIT ignores bad headers for 32 cycles, next bad header slips again
    snap = slip_total;
    send(2'b11, 1'b1, 1);
    chk("wait_slip_one_cycle", 64'(bitslip), 64'd0);
    chk("wait_oval", 64'(out_valid), 64'd0);
    send(2'b11, 1'b1, 32);
    chk("wait_no_slip", 64'(bitslip), 64'd0);
    chk("wait_pulses", 64'(slip_total - snap), 64'd1);
    send(2'b11, 1'b1, 1);
    chk("wait_reslip", 64'(bitslip), 64'd1);

    // Relock after slip
    snap = slip_total;
    send(2'b01, 1'b1, 33);
    send(2'b01, 1'b1, 63);
    chk("relock_63", 64'(block_lock), 64'd0);
    send(2'b01, 1'b1, 1);
    chk("relock_64", 64'(block_lock), 64'd1);
    chk("relock_pulses", 64'(slip_total - snap), 64'd1);

    // Reset while LOCKED
    rst = 1'b1;
    send(2'b10, 1'b1, 1);
    chk_reset_outputs("rst_locked");
    rst = 1'b0;
    send(2'b11, 1'b0, 1);

    // Gapped acquisition
    snap = slip_total;
    for (int k = 0; k < 63; k++) begin
      send(2'b01, 1'b1, 1); send(2'b11, 1'b0, 1);
    end
    chk("gap_lock_63", 64'(block_lock), 64'd0);
    send(2'b01, 1'b1, 1);
    last_data = data_in;
    chk("gap_lock_64", 64'(block_lock), 64'd1);
    send(2'b11, 1'b0, 1);
    chk("gap_hold_oval", 64'(out_valid), 64'd0);
    chk("gap_hold_data", data_out, last_data);
    chk("gap_hold_hdr", 64'(hdr_out), 64'd1);
    chk("gap_hold_err", 64'(err_count), 64'd0);
    chk("gap_no_slip", 64'(slip_total - snap), 64'd0);

    // Consecutive bad headers drop lock, then reset during WAIT
    send(2'b00, 1'b1, 15);
    chk("burst_lock_15", 64'(block_lock), 64'd1);
    send(2'b00, 1'b1, 1);
    chk("burst_lock", 64'(block_lock), 64'd0);
    chk("burst_slip", 64'(bitslip), 64'd1);
    chk("burst_err", 64'(err_count), 64'd16);
    send(2'b11, 1'b1, 5);
    rst = 1'b1;
    send(2'b11, 1'b1, 1);
    chk_reset_outputs("rst_wait");
    rst = 1'b0;
    snap = slip_total;
    send(2'b01, 1'b1, 40);
    chk("post_rst_no_slip", 64'(slip_total - snap), 64'd0);
    chk("post_rst_lock", 64'(block_lock), 64'd0);
    send(2'b11, 1'b1, 1);
    chk("post_rst_slip", 64'(bitslip), 64'd1);

    send(2'b01, 1'b0, 2);
    chk("no_back_to_back", 64'(b2b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
